sdcard_cmd_scheduler: RTL and testbench

Arbitrates SD command traffic from several on-chip requesters onto the single SD command engine. Typical requesters: init/enumeration sequencer, data engine (CMD12/CMD23), APB host. The block owns the engine's `cmd_index`/`cmd_argument`/`cmd_start` inputs and consumes its busy/done/timeout/CRC-error outputs. It automatically prefixes application commands with CMD55, retries failed commands, and returns a per-requester response with a status code.

---
 rtl/sdcard_cmd_scheduler.sv | 266 ++++++++++++++++++++++++++
 tb/tb_sdcard_cmd_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdcard_cmd_scheduler.sv
// sdcard_cmd_scheduler: arbitrates SD command requests from NUM_REQ requesters
// onto one SD command engine. Requester 0 is urgent; others share round-robin.
// Application commands get an automatic CMD55 prefix, failed commands are
// retried up to MAX_RETRY times, and the owner receives one response pulse.
// Optional statistics counters: define SDCARD_CMD_SCHED_STATS_EN.
//
// Handshake: req_valid[k] is held by requester k until req_ready[k] pulses for
// one cycle (the accept cycle); fields are captured on that cycle. rsp_valid
// is a one-cycle pulse with no back-pressure; rsp_data/rsp_status stay put
// until the next response.
module sdcard_cmd_scheduler #(
    parameter int NUM_REQ   = 3,
    parameter int MAX_RETRY = 2,
    parameter int START_TO  = 16
) (
    input  logic                  PCLK_i,
    input  logic                  PRESETn_i,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [6*NUM_REQ-1:0]  req_index,
    input  logic [32*NUM_REQ-1:0] req_arg,
    input  logic [NUM_REQ-1:0]    req_app,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [39:0]           rsp_data,
    output logic [1:0]            rsp_status,
    input  logic [15:0]           rca_i,
    output logic [5:0]            eng_cmd_index,
    output logic [31:0]           eng_cmd_argument,
    output logic                  eng_cmd_start,
    input  logic                  eng_cmd_busy,
    input  logic                  eng_cmd_done,
    input  logic [39:0]           eng_cmd_response,
    input  logic                  eng_cmd_timeout,
    input  logic                  eng_cmd_crc_error,
    output logic [15:0]           stat_cmds,
    output logic [15:0]           stat_retries,
    output logic [2:0]            dbg_state
);

    localparam int IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE_APP = 3'd1,
        S_WAIT_APP  = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT      = 3'd4,
        S_RESP      = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] rr_q, rr_d, owner_q, owner_d;
    logic [5:0]    idx_q, idx_d, eng_idx_q, eng_idx_d;
    logic [31:0]   arg_q, arg_d, eng_arg_q, eng_arg_d;
    logic          app_q, app_d;
    logic [2:0]    retry_q, retry_d;
    logic [15:0]   wd_q, wd_d;
    logic [39:0]   rsp_data_q, rsp_data_d;
    logic [1:0]    rsp_status_q, rsp_status_d;

    logic          grant_found;
    logic [IW-1:0] grant_id;
    logic [5:0]    win_index;
    logic [31:0]   win_arg;
    logic          win_app;

    // Arbitration: requester 0 first, then round-robin from rr up, then wrap below rr.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        if (req_valid[0]) begin
            grant_found = 1'b1;
        end else begin
            for (int j = 1; j < NUM_REQ; j++) begin
                if (!grant_found && j >= int'(rr_q) && req_valid[j]) begin
                    grant_found = 1'b1;
                    grant_id    = IW'(j);
                end
            end
            for (int j = 1; j < NUM_REQ; j++) begin
                if (!grant_found && j < int'(rr_q) && req_valid[j]) begin
                    grant_found = 1'b1;
                    grant_id    = IW'(j);
                end
            end
        end
    end

    // Mux the winning requester's command fields.
    always_comb begin
        win_index = '0;
        win_arg   = '0;
        win_app   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == grant_id) begin
                win_index = req_index[6*i +: 6];
                win_arg   = req_arg[32*i +: 32];
                win_app   = req_app[i];
            end
        end
    end

    // Next-state logic; engine command registers are loaded on entry to an issue state.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        owner_d      = owner_q;
        idx_d        = idx_q;
        arg_d        = arg_q;
        app_d        = app_q;
        retry_d      = retry_q;
        wd_d         = wd_q;
        eng_idx_d    = eng_idx_q;
        eng_arg_d    = eng_arg_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    owner_d = grant_id;
                    idx_d   = win_index;
                    arg_d   = win_arg;
                    app_d   = win_app;
                    retry_d = '0;
                    if (grant_id != '0)
                        rr_d = (grant_id == IW'(NUM_REQ-1)) ? IW'(1) : grant_id + IW'(1);
                    if (win_app) begin
                        state_d   = S_ISSUE_APP;
                        eng_idx_d = 6'h37;
                        eng_arg_d = {rca_i, 16'h0000};
                    end else begin
                        state_d   = S_ISSUE;
                        eng_idx_d = win_index;
                        eng_arg_d = win_arg;
                    end
                end
            end
            S_ISSUE_APP: begin
                wd_d    = 16'd1;
                state_d = S_WAIT_APP;
            end
            S_ISSUE: begin
                wd_d    = 16'd1;
                state_d = S_WAIT;
            end
            S_WAIT_APP, S_WAIT: begin
                if (eng_cmd_done) begin
                    if (state_q == S_WAIT_APP) begin
                        state_d   = S_ISSUE;
                        eng_idx_d = idx_q;
                        eng_arg_d = arg_q;
                    end else begin
                        state_d      = S_RESP;
                        rsp_data_d   = eng_cmd_response;
                        rsp_status_d = 2'b00;
                    end
                end else if (eng_cmd_crc_error || eng_cmd_timeout) begin
                    if (retry_q < 3'(MAX_RETRY)) begin
                        retry_d = retry_q + 3'd1;
                        if (app_q) begin
                            state_d   = S_ISSUE_APP;
                            eng_idx_d = 6'h37;
                            eng_arg_d = {rca_i, 16'h0000};
                        end else begin
                            state_d   = S_ISSUE;
                            eng_idx_d = idx_q;
                            eng_arg_d = arg_q;
                        end
                    end else begin
                        state_d      = S_RESP;
                        rsp_data_d   = '0;
                        rsp_status_d = eng_cmd_crc_error ? 2'b10 : 2'b01;
                    end
                end else if (!eng_cmd_busy) begin
                    // The start cycle counts as 1, so RESP lands START_TO cycles after start.
                    if (wd_q >= 16'(START_TO-1)) begin
                        state_d      = S_RESP;
                        rsp_data_d   = '0;
                        rsp_status_d = 2'b11;
                    end else begin
                        wd_d = wd_q + 16'd1;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            state_q      <= S_IDLE;
            rr_q         <= IW'(1);
            owner_q      <= '0;
            idx_q        <= '0;
            arg_q        <= '0;
            app_q        <= 1'b0;
            retry_q      <= '0;
            wd_q         <= '0;
            eng_idx_q    <= '0;
            eng_arg_q    <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            owner_q      <= owner_d;
            idx_q        <= idx_d;
            arg_q        <= arg_d;
            app_q        <= app_d;
            retry_q      <= retry_d;
            wd_q         <= wd_d;
            eng_idx_q    <= eng_idx_d;
            eng_arg_q    <= eng_arg_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign req_ready        = (state_q == S_IDLE && grant_found) ? (NUM_REQ'(1) << grant_id) : '0;
    assign rsp_valid        = (state_q == S_RESP) ? (NUM_REQ'(1) << owner_q) : '0;
    assign rsp_data         = rsp_data_q;
    assign rsp_status       = rsp_status_q;
    assign eng_cmd_index    = eng_idx_q;
    assign eng_cmd_argument = eng_arg_q;
    assign eng_cmd_start    = (state_q == S_ISSUE_APP) || (state_q == S_ISSUE);
    assign dbg_state        = state_q;

`ifdef SDCARD_CMD_SCHED_STATS_EN
    logic [15:0] stat_cmds_q, stat_cmds_d, stat_retries_q, stat_retries_d;

    // Saturating counters: responses delivered and retries issued.
    always_comb begin
        stat_cmds_d    = stat_cmds_q;
        stat_retries_d = stat_retries_q;
        if (state_q == S_RESP && stat_cmds_q != 16'hFFFF)
            stat_cmds_d = stat_cmds_q + 16'd1;
        if ((state_q == S_WAIT || state_q == S_WAIT_APP) && retry_d != retry_q &&
            stat_retries_q != 16'hFFFF)
            stat_retries_d = stat_retries_q + 16'd1;
    end

    // Statistics registers.
    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            stat_cmds_q    <= '0;
            stat_retries_q <= '0;
        end else begin
            stat_cmds_q    <= stat_cmds_d;
            stat_retries_q <= stat_retries_d;
        end
    end

    assign stat_cmds    = stat_cmds_q;
    assign stat_retries = stat_retries_q;
`else
    assign stat_cmds    = '0;
    assign stat_retries = '0;
`endif

endmodule

// File: tb/tb_sdcard_cmd_scheduler.sv
// Directed testbench for sdcard_cmd_scheduler (NUM_REQ=3, MAX_RETRY=2, START_TO=16).
module tb_sdcard_cmd_scheduler;

    localparam int NR       = 3;
    localparam int START_TO = 16;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [6*NR-1:0] req_index;
    logic [32*NR-1:0] req_arg;
    logic [NR-1:0]   req_app;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [39:0]     rsp_data;
    logic [1:0]      rsp_status;
    logic [15:0]     rca;
    logic [5:0]      eng_cmd_index;
    logic [31:0]     eng_cmd_argument;
    logic            eng_cmd_start;
    logic            eng_busy;
    logic            eng_done;
    logic [39:0]     eng_resp;
    logic            eng_to;
    logic            eng_crc;
    logic [15:0]     stat_cmds;
    logic [15:0]     stat_retries;
    logic [2:0]      dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [44:0] exp_q[$];

    sdcard_cmd_scheduler #(.NUM_REQ(NR), .MAX_RETRY(2), .START_TO(START_TO)) dut (
        .PCLK_i            (clk),
        .PRESETn_i         (rst_n),
        .req_valid         (req_valid),
        .req_index         (req_index),
        .req_arg           (req_arg),
        .req_app           (req_app),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .rsp_status        (rsp_status),
        .rca_i             (rca),
        .eng_cmd_index     (eng_cmd_index),
        .eng_cmd_argument  (eng_cmd_argument),
        .eng_cmd_start     (eng_cmd_start),
        .eng_cmd_busy      (eng_busy),
        .eng_cmd_done      (eng_done),
        .eng_cmd_response  (eng_resp),
        .eng_cmd_timeout   (eng_to),
        .eng_cmd_crc_error (eng_crc),
        .stat_cmds         (stat_cmds),
        .stat_retries      (stat_retries),
        .dbg_state         (dbg_state)
    );

    // Clock and run-time bound.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [44:0] mk(input logic [2:0] own, input logic [1:0] st,
                                       input logic [39:0] data);
        return {own, st, data};
    endfunction

    // Scoreboard: every response pulse must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                logic [44:0] e;
                e = exp_q.pop_front();
                check("rsp_payload", 64'({rsp_valid, rsp_status, rsp_data}), 64'(e));
            end
        end
    end

    task automatic set_req(input int k, input logic [5:0] idx, input logic [31:0] arg,
                           input logic app);
        req_index[k*6 +: 6]  = idx;
        req_arg[k*32 +: 32]  = arg;
        req_app[k]           = app;
        req_valid[k]         = 1'b1;
    endtask

    // Waits for an accept, checks the winner, drops its valid, and lands on the start cycle.
    task automatic wait_grant(input string tag, input logic [2:0] exp_g);
        int n;
        logic [2:0] g;
        n = 0;
        #1;
        while (req_ready == '0 && n < 50) begin
            step();
            n++;
        end
        g = req_ready;
        check(tag, 64'(g), 64'(exp_g));
        step();
        req_valid = req_valid & ~g;
        check({tag, "_start"}, 64'(eng_cmd_start), 64'd1);
    endtask

    // Engine model: kind 0 done, 1 timeout, 2 crc error, 3 done+crc together.
    // Returns in the cycle after the completion pulse.
    task automatic engine(input int kind, input logic [39:0] resp);
        step();
        eng_busy = 1'b1;
        step();
        step();
        eng_busy = 1'b0;
        eng_done = (kind == 0 || kind == 3);
        eng_to   = (kind == 1);
        eng_crc  = (kind == 2 || kind == 3);
        eng_resp = resp;
        step();
        eng_done = 1'b0;
        eng_to   = 1'b0;
        eng_crc  = 1'b0;
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        req_valid = '0;
        req_index = '0;
        req_arg   = '0;
        req_app   = '0;
        rca       = 16'h1234;
        eng_busy  = 1'b0;
        eng_done  = 1'b0;
        eng_resp  = '0;
        eng_to    = 1'b0;
        eng_crc   = 1'b0;
        step();
        step();
        check("rst_start", 64'(eng_cmd_start), 64'd0);
        check("rst_index", 64'(eng_cmd_index), 64'd0);
        check("rst_arg", 64'(eng_cmd_argument), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_stat_retries", 64'(stat_retries), 64'd0);
        rst_n = 1'b1;
        step();

        // Round-robin: 1 then 2 with both held, then 0 overrides, then back to 1.
        set_req(1, 6'd17, 32'h0000_1000, 1'b0);
        set_req(2, 6'd18, 32'h0000_2000, 1'b0);
        wait_grant("grant_a", 3'b010);
        check("a_index", 64'(eng_cmd_index), 64'd17);
        check("a_arg", 64'(eng_cmd_argument), 64'h1000);
        set_req(1, 6'd17, 32'h0000_1000, 1'b0);
        exp_q.push_back(mk(3'b010, 2'b00, 40'hA5_0000_0900));
        engine(0, 40'hA5_0000_0900);
        check("a_rsp_time", 64'(rsp_valid), 64'b010);
        step();
        check("a_hold_data", 64'(rsp_data), 64'hA5_0000_0900);
        wait_grant("grant_b", 3'b100);
        check("b_index", 64'(eng_cmd_index), 64'd18);
        exp_q.push_back(mk(3'b100, 2'b00, 40'h00_0000_0B0B));
        engine(0, 40'h00_0000_0B0B);
        check("b_rsp_time", 64'(rsp_valid), 64'b100);
        step();
        set_req(0, 6'd13, 32'h0000_0C00, 1'b0);
        set_req(2, 6'd18, 32'h0000_2000, 1'b0);
        wait_grant("grant_c", 3'b001);
        exp_q.push_back(mk(3'b001, 2'b00, 40'h00_0000_0C0C));
        engine(0, 40'h00_0000_0C0C);
        step();
        wait_grant("grant_d", 3'b010);
        req_valid[2] = 1'b0;
        exp_q.push_back(mk(3'b010, 2'b00, 40'h00_0000_0D0D));
        engine(0, 40'h00_0000_0D0D);
        step();

        // ACMD41: CMD55 prefix with RCA, then the command itself.
        set_req(2, 6'h29, 32'h40FF_8000, 1'b1);
        wait_grant("grant_acmd", 3'b100);
        check("acmd_cmd55_index", 64'(eng_cmd_index), 64'h37);
        check("acmd_cmd55_arg", 64'(eng_cmd_argument), 64'h1234_0000);
        engine(0, 40'h00_0000_0120);
        check("acmd_second_start", 64'(eng_cmd_start), 64'd1);
        check("acmd_index", 64'(eng_cmd_index), 64'h29);
        check("acmd_arg", 64'(eng_cmd_argument), 64'h40FF_8000);
        check("acmd_no_early_rsp", 64'(rsp_valid), 64'd0);
        exp_q.push_back(mk(3'b100, 2'b00, 40'h00_80FF_8000));
        engine(0, 40'h00_80FF_8000);
        check("acmd_rsp_time", 64'(rsp_valid), 64'b100);
        step();
        req_app[2] = 1'b0;

        // Three timeouts: two retries, then status 01 with zero data.
        set_req(1, 6'd8, 32'h0000_01AA, 1'b0);
        wait_grant("grant_retry", 3'b010);
        exp_q.push_back(mk(3'b010, 2'b01, 40'h0));
        engine(1, 40'hFF_FFFF_FFFF);
        check("retry1_start", 64'(eng_cmd_start), 64'd1);
        check("retry1_index", 64'(eng_cmd_index), 64'd8);
        engine(1, 40'hFF_FFFF_FFFF);
        check("retry2_start", 64'(eng_cmd_start), 64'd1);
        engine(1, 40'hFF_FFFF_FFFF);
        check("retry_rsp_time", 64'(rsp_valid), 64'b010);
        check("retry_no_4th_start", 64'(eng_cmd_start), 64'd0);
`ifdef SDCARD_CMD_SCHED_STATS_EN
        check("stat_retries", 64'(stat_retries), 64'd2);
`else
        check("stat_retries", 64'(stat_retries), 64'd0);
`endif
        step();
`ifdef SDCARD_CMD_SCHED_STATS_EN
        check("stat_cmds", 64'(stat_cmds), 64'd6);
`else
        check("stat_cmds", 64'(stat_cmds), 64'd0);
`endif

        // done and crc together: done wins.
        set_req(2, 6'd24, 32'h0000_3000, 1'b0);
        wait_grant("grant_prio", 3'b100);
        exp_q.push_back(mk(3'b100, 2'b00, 40'h00_0000_0900));
        engine(3, 40'h00_0000_0900);
        check("prio_rsp_time", 64'(rsp_valid), 64'b100);
        step();

        // Mixed failures ending on CRC: status 10.
        set_req(1, 6'd25, 32'h0000_4000, 1'b0);
        wait_grant("grant_crc", 3'b010);
        exp_q.push_back(mk(3'b010, 2'b10, 40'h0));
        engine(1, 40'h0);
        engine(2, 40'h0);
        engine(2, 40'h12_3456_789A);
        check("crc_rsp_time", 64'(rsp_valid), 64'b010);
        step();

        // Engine never goes busy: status 11 START_TO cycles after start.
        set_req(2, 6'd13, 32'h0, 1'b0);
        wait_grant("grant_nobusy", 3'b100);
        exp_q.push_back(mk(3'b100, 2'b11, 40'h0));
        n = 0;
        while (rsp_valid == '0 && n < 100) begin
            step();
            n++;
        end
        check("start_to_latency", 64'(n), 64'(START_TO));
        step();

        // Reset during WAIT: outputs clear at once, no stale response afterwards.
        set_req(1, 6'd17, 32'h0000_2000, 1'b0);
        wait_grant("grant_rst", 3'b010);
        step();
        eng_busy = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_start", 64'(eng_cmd_start), 64'd0);
        check("rst_mid_index", 64'(eng_cmd_index), 64'd0);
        check("rst_mid_arg", 64'(eng_cmd_argument), 64'd0);
        check("rst_mid_status", 64'(rsp_status), 64'd0);
        check("rst_mid_state", 64'(dbg_state), 64'd0);
        eng_busy = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_mid_stat_cmds", 64'(stat_cmds), 64'd0);
        set_req(2, 6'd17, 32'h0000_3000, 1'b0);
        wait_grant("grant_after_rst", 3'b100);
        check("after_rst_arg", 64'(eng_cmd_argument), 64'h3000);
        exp_q.push_back(mk(3'b100, 2'b00, 40'h5A_0000_0900));
        engine(0, 40'h5A_0000_0900);
        check("after_rst_rsp_time", 64'(rsp_valid), 64'b100);
        step();
        step();
        step();
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
